direction_pad: RTL and testbench

Input front end for the snake game. It synchronizes and debounces the five raw board push-buttons (up, down, left, right, start). It arbitrates the four direction buttons into the one-hot `movement` code the game core consumes, and presents a clean `start` level plus a one-cycle `start_pulse`. It sits between the board pins and the game's `movement`/`start` inputs, on the system clock.

---
 rtl/direction_pad_pkg.sv | 38 +++
 rtl/direction_pad_debounce_cell.sv | 54 +++++
 rtl/direction_pad.sv | 134 +++++++++++++
 tb/tb_direction_pad.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/direction_pad_pkg.sv
// direction_pad_pkg: shared direction codes, arbiter state type and helpers
// for the snake-game button front end.
package direction_pad_pkg;

    typedef logic [3:0] dir_t;

    localparam dir_t DIR_NONE  = 4'b0000;
    localparam dir_t DIR_UP    = 4'b0001;
    localparam dir_t DIR_DOWN  = 4'b0010;
    localparam dir_t DIR_LEFT  = 4'b0100;
    localparam dir_t DIR_RIGHT = 4'b1000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_t;

    // Reverse of a one-hot direction; anything else maps to no direction.
    function automatic dir_t opposite(input dir_t d);
        case (d)
            DIR_UP:    return DIR_DOWN;
            DIR_DOWN:  return DIR_UP;
            DIR_LEFT:  return DIR_RIGHT;
            DIR_RIGHT: return DIR_LEFT;
            default:   return DIR_NONE;
        endcase
    endfunction

    // Fixed priority UP > DOWN > LEFT > RIGHT over a set of candidates.
    function automatic dir_t highest_priority(input dir_t mask);
        if (mask[0])      return DIR_UP;
        else if (mask[1]) return DIR_DOWN;
        else if (mask[2]) return DIR_LEFT;
        else if (mask[3]) return DIR_RIGHT;
        else              return DIR_NONE;
    endfunction

endpackage

// File: rtl/direction_pad_debounce_cell.sv
// debounce_cell: 2-flop synchronizer followed by a stability counter.
// A new level is accepted once the synchronized input has differed from
// the stable level for DEBOUNCE_CYCLES consecutive cycles; rise flags the
// accepted 0->1 change for exactly one cycle.
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic stable,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt;

    // Bring the raw pin into the clock domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
        end
    end

    // Count consecutive mismatches; accept the new level on the cycle the
    // count would reach DEBOUNCE_CYCLES.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (sync_q2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt    <= '0;
                stable <= sync_q2;
                rise   <= sync_q2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/direction_pad.sv
// direction_pad: debounces the five board buttons and arbitrates the four
// direction buttons into a one-hot movement code for the game core.
// Optional build macro DIRECTION_PAD_REVERSE_FILTER_EN: ignore presses that
// would reverse the most recent direction (last_dir).
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | no direction selected, movement = 0
// ST_HOLD | cur holds the selected direction, movement = cur
module direction_pad
    import direction_pad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_start,
    output logic [3:0] movement,
    output logic       start,
    output logic       start_pulse
);

    // bit 0..3 follow the one-hot direction code, bit 4 is start
    logic [4:0] raw;
    logic [4:0] stable;
    logic [4:0] rise;

    assign raw = {btn_start, btn_right, btn_left, btn_down, btn_up};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .btn   (raw[i]),
            .stable(stable[i]),
            .rise  (rise[i])
        );
    end

    arb_state_t state;
    dir_t       cur;
    dir_t       blocked;
    dir_t       press;
    dir_t       held;
    dir_t       press_pick;
    dir_t       held_pick;

`ifdef DIRECTION_PAD_REVERSE_FILTER_EN
    dir_t last_dir;
    assign blocked = opposite(last_dir);
`else
    assign blocked = DIR_NONE;
`endif

    // Blocked directions neither start a hold nor serve as fallback.
    assign press      = rise[3:0] & ~blocked;
    assign held       = stable[3:0] & ~blocked;
    assign press_pick = highest_priority(press);
    assign held_pick  = highest_priority(held);

    // Arbiter: a new press always wins; releasing cur falls back to the
    // best direction still held, or returns to idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cur      <= DIR_NONE;
            movement <= DIR_NONE;
`ifdef DIRECTION_PAD_REVERSE_FILTER_EN
            last_dir <= DIR_NONE;
`endif
        end else begin
`ifdef DIRECTION_PAD_REVERSE_FILTER_EN
            // a direction chosen on this same edge overrides the clear below
            if (start_pulse) last_dir <= DIR_NONE;
`endif
            case (state)
                ST_IDLE: begin
                    if (press != DIR_NONE) begin
                        state    <= ST_HOLD;
                        cur      <= press_pick;
                        movement <= press_pick;
`ifdef DIRECTION_PAD_REVERSE_FILTER_EN
                        last_dir <= press_pick;
`endif
                    end
                end
                ST_HOLD: begin
                    if (press != DIR_NONE) begin
                        cur      <= press_pick;
                        movement <= press_pick;
`ifdef DIRECTION_PAD_REVERSE_FILTER_EN
                        last_dir <= press_pick;
`endif
                    end else if ((cur & stable[3:0]) == DIR_NONE) begin
                        if (held != DIR_NONE) begin
                            cur      <= held_pick;
                            movement <= held_pick;
`ifdef DIRECTION_PAD_REVERSE_FILTER_EN
                            last_dir <= held_pick;
`endif
                        end else begin
                            state    <= ST_IDLE;
                            cur      <= DIR_NONE;
                            movement <= DIR_NONE;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    cur      <= DIR_NONE;
                    movement <= DIR_NONE;
                end
            endcase
        end
    end

    // Start level and its one-cycle press pulse, both registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start       <= 1'b0;
            start_pulse <= 1'b0;
        end else begin
            start       <= stable[4];
            start_pulse <= rise[4];
        end
    end

endmodule

// File: tb/tb_direction_pad.sv
// tb_direction_pad: directed scenarios plus randomized button activity,
// compared cycle by cycle against a sample-window reference model.
module tb_direction_pad;

    localparam int D = 4;
`ifdef DIRECTION_PAD_REVERSE_FILTER_EN
    localparam bit USE_FILTER = 1'b1;
`else
    localparam bit USE_FILTER = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] btn;            // up, down, left, right, start
    logic [3:0] movement;
    logic       start;
    logic       start_pulse;

    int n_checks = 0;
    int n_pass   = 0;

    direction_pad #(.DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_up     (btn[0]),
        .btn_down   (btn[1]),
        .btn_left   (btn[2]),
        .btn_right  (btn[3]),
        .btn_start  (btn[4]),
        .movement   (movement),
        .start      (start),
        .start_pulse(start_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // raw sample history per button, newest in bit 0
    logic [D+1:0] hist [5];
    logic [4:0]   m_stab;
    logic [4:0]   m_rise;
    logic [3:0]   m_move;
    logic [3:0]   m_last;
    logic         m_start;
    logic         m_pulse;

    function automatic logic [3:0] first_of(input logic [3:0] m);
        return m & (~m + 4'd1);
    endfunction

    function automatic logic [3:0] flip_dir(input logic [3:0] d);
        return {d[2], d[3], d[0], d[1]};
    endfunction

    // New level accepted when the D synchronized samples the logic has seen
    // (two edges of synchronizer delay) all differ from the stable level.
    function automatic logic db_accept(input logic [D+1:0] h, input logic st);
        for (int k = 2; k <= D + 1; k++)
            if (h[k] == st) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] arb_next(input logic [3:0] mv, input logic [3:0] rs,
                                            input logic [3:0] st, input logic [3:0] last);
        logic [3:0] filt;
        logic [3:0] pr;
        filt = USE_FILTER ? flip_dir(last) : 4'd0;
        pr   = rs & ~filt;
        if (pr != 4'd0) return first_of(pr);
        if (mv != 4'd0 && (mv & st) == 4'd0) return first_of(st & ~filt);
        return mv;
    endfunction

    function automatic logic [3:0] last_next(input logic [3:0] last, input logic [3:0] mv,
                                             input logic [3:0] nx, input logic pulse);
        if (nx != 4'd0 && nx != mv) return nx;
        if (pulse) return 4'd0;
        return last;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 5; b++) hist[b] <= '0;
            m_stab  <= '0;
            m_rise  <= '0;
            m_move  <= '0;
            m_last  <= '0;
            m_start <= 1'b0;
            m_pulse <= 1'b0;
        end else begin
            m_move  <= arb_next(m_move, m_rise[3:0], m_stab[3:0], m_last);
            m_last  <= last_next(m_last, m_move,
                                 arb_next(m_move, m_rise[3:0], m_stab[3:0], m_last), m_pulse);
            m_start <= m_stab[4];
            m_pulse <= m_rise[4];
            for (int b = 0; b < 5; b++) begin
                hist[b]   <= {hist[b][D:0], btn[b]};
                m_stab[b] <= db_accept({hist[b][D:0], btn[b]}, m_stab[b]) ? ~m_stab[b] : m_stab[b];
                m_rise[b] <= db_accept({hist[b][D:0], btn[b]}, m_stab[b]) & ~m_stab[b];
            end
        end
    end

    // continuous comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("model_movement", 32'(movement), 32'(m_move));
        check("model_start", 32'(start), 32'(m_start));
        check("model_start_pulse", 32'(start_pulse), 32'(m_pulse));
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [3:0] exp6;

    initial begin
        reset = 1'b0;
        btn   = '0;
        #1;
        check("reset_movement", 32'(movement), 32'd0);
        check("reset_start", 32'(start), 32'd0);
        check("reset_pulse", 32'(start_pulse), 32'd0);
        step(3);
        reset = 1'b1;
        step(3);

        // hold up, then release: press and release latency
        btn[0] = 1'b1;
        step(6); check("up_press_early", 32'(movement), 32'd0);
        step(1); check("up_press", 32'(movement), 32'd1);
        btn[0] = 1'b0;
        step(6); check("up_release_early", 32'(movement), 32'd1);
        step(1); check("up_release", 32'(movement), 32'd0);
        step(4);

        // bouncing left: 3-cycle pulses with 2-cycle gaps never accepted
        for (int r = 0; r < 5; r++) begin
            btn[2] = 1'b1; step(3);
            btn[2] = 1'b0; step(2);
        end
        step(8);
        check("left_bounce", 32'(movement), 32'd0);

        // newest press wins, release falls back to the still-held direction
        btn[3] = 1'b1;
        step(7); check("right_press", 32'(movement), 32'd8);
        btn[0] = 1'b1;
        step(7); check("up_over_right", 32'(movement), 32'd1);
        btn[0] = 1'b0;
        step(6); check("fallback_early", 32'(movement), 32'd1);
        step(1); check("fallback_right", 32'(movement), 32'd8);
        btn[3] = 1'b0;
        step(7); check("right_release", 32'(movement), 32'd0);
        step(3);

        // same-cycle presses resolve by priority
        btn[0] = 1'b1; btn[3] = 1'b1;
        step(7); check("same_cycle_prio", 32'(movement), 32'd1);
        btn[0] = 1'b0; btn[3] = 1'b0;
        step(10);

        // start held 20 cycles: one pulse, level follows
        btn[4] = 1'b1;
        step(6);
        check("start_early", 32'(start), 32'd0);
        check("start_pulse_early", 32'(start_pulse), 32'd0);
        step(1);
        check("start_level", 32'(start), 32'd1);
        check("start_pulse_on", 32'(start_pulse), 32'd1);
        step(1);
        check("start_pulse_off", 32'(start_pulse), 32'd0);
        check("start_still", 32'(start), 32'd1);
        step(12);
        btn[4] = 1'b0;
        step(7);
        check("start_release", 32'(start), 32'd0);
        step(3);

        // reversal while holding right
`ifdef DIRECTION_PAD_REVERSE_FILTER_EN
        exp6 = 4'd8;
`else
        exp6 = 4'd4;
`endif
        btn[3] = 1'b1;
        step(7); check("rev_right", 32'(movement), 32'd8);
        btn[2] = 1'b1;
        step(7); check("rev_left", 32'(movement), 32'(exp6));
        btn[2] = 1'b0; btn[3] = 1'b0;
        step(10);

        // reset mid-hold, button kept down through the reset
        btn[1] = 1'b1;
        step(7); check("down_press", 32'(movement), 32'd2);
        #2 reset = 1'b0;
        #1;
        check("async_reset_movement", 32'(movement), 32'd0);
        check("async_reset_start", 32'(start), 32'd0);
        check("async_reset_pulse", 32'(start_pulse), 32'd0);
        step(3);
        reset = 1'b1;
        step(6); check("post_reset_early", 32'(movement), 32'd0);
        step(1); check("post_reset_down", 32'(movement), 32'd2);
        btn[1] = 1'b0;
        step(10);

        // randomized activity: bouncy phase, then cleaner presses
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int b = 0; b < 5; b++)
                if ($urandom_range(0, 2) == 0) btn[b] = ~btn[b];
        end
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (c == 700) begin
                #3 reset = 1'b0;
            end else if (c == 703) begin
                reset = 1'b1;
            end
            for (int b = 0; b < 5; b++)
                if ($urandom_range(0, 24) == 0) btn[b] = ~btn[b];
        end
        btn = '0;
        step(12);
        check("final_idle", 32'(movement), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
